// File: rtl/pc_ir_unit_pkg.sv
// pc_ir_unit_pkg
//   Definitions shared by the fetch datapath and the control unit:
//   - next-PC source select codes
//   - the HALT opcode
//   - the reset PC default
//   - run/halt state codes
//   - a packed view of the R-type instruction fields
package pc_ir_unit_pkg;

  // Next-PC source select, driven by the control unit.
  localparam logic [1:0] PC_SEL_NEXT_INS = 2'b00;
  localparam logic [1:0] PC_SEL_REL_JMP  = 2'b01;
  localparam logic [1:0] PC_SEL_RS_JMP   = 2'b10;
  localparam logic [1:0] PC_SEL_ABS_JMP  = 2'b11;

  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Run/halt state encoding.
  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_HALT = 1'b1;

  // Field layout of a 32-bit instruction; the widths add up to exactly 32 bits.
  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] sa;
    logic [5:0] func;
  } instr_fields_t;

endpackage

// File: rtl/pc_ir_unit_next_pc_calc.sv
// next_pc_calc
//   Purely combinational next-PC selection.
//   inputs : pc       current PC
//            ir       latched instruction
//            rs_data  register rs value, used for jr
//            pc_sel   next-PC source select
//   outputs: pc_plus4       pc + 4
//            next_pc        selected next PC
//            misalign_cond  jr target has nonzero low bits
//   All arithmetic wraps modulo 2^PC_W.
module next_pc_calc
  import pc_ir_unit_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] ir,
  input  logic [PC_W-1:0] rs_data,
  input  logic [1:0]      pc_sel,
  output logic [PC_W-1:0] pc_plus4,
  output logic [PC_W-1:0] next_pc,
  output logic            misalign_cond
);

  logic [PC_W-1:0] branch_off;

  always_comb begin
    pc_plus4 = pc + PC_W'(4);

    // Sign-extend immd16, then scale it to a byte offset (shift left by 2).
    branch_off = {{(PC_W-18){ir[15]}}, ir[15:0], 2'b00};

    next_pc = pc_plus4;
    case (pc_sel)
      PC_SEL_NEXT_INS: next_pc = pc_plus4;
      PC_SEL_REL_JMP:  next_pc = pc_plus4 + branch_off;
      PC_SEL_RS_JMP:   next_pc = {rs_data[PC_W-1:2], 2'b00};
      PC_SEL_ABS_JMP:  next_pc = {pc_plus4[PC_W-1:PC_W-4], ir[25:0], 2'b00};
      default:         next_pc = pc_plus4;
    endcase

    // The jr target is forced to alignment; this flag only reports that it
    // was needed.
    misalign_cond = (pc_sel == PC_SEL_RS_JMP) && (rs_data[1:0] != 2'b00);
  end

endmodule

// File: rtl/pc_ir_unit.sv
// pc_ir_unit
//   Fetch-side datapath: holds the program counter and the instruction
//   register, and splits the IR into fields.
//
//   Control inputs:
//     CLK, nRST  clock; asynchronous active-low reset
//     pc_write   commit the next PC at this edge
//     ir_write   latch instr_in into the IR at this edge
//     pc_sel     next-PC source
//   Data inputs:
//     rs_data    jr target
//     instr_in   instruction-memory read data
//   Outputs:
//     pc                     current PC, also the instruction-memory address
//     pc_plus4               pc + 4
//     op/rs/rt/rd/sa/func/immd16  IR fields
//     halted                 processor has stopped on HALT
//     misalign               sticky jr-misalignment flag
//
//   Once HALT is latched, pc, IR and misalign freeze until reset.
module pc_ir_unit
  import pc_ir_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          PC_W     = 32
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            pc_write,
  input  logic            ir_write,
  input  logic [1:0]      pc_sel,
  input  logic [PC_W-1:0] rs_data,
  input  logic [PC_W-1:0] instr_in,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus4,
  output logic [5:0]      op,
  output logic [5:0]      func,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      rd,
  output logic [4:0]      sa,
  output logic [15:0]     immd16,
  output logic            halted,
  output logic            misalign
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] ir_q, ir_d;
  logic [0:0]      state_q, state_d;
  logic            misalign_q, misalign_d;

  logic [PC_W-1:0] next_pc;
  logic            misalign_cond;
  logic            running;
  logic            halt_latch;
  logic            pc_en;
  instr_fields_t   fields;

  next_pc_calc #(.PC_W(PC_W)) u_next_pc_calc (
    .pc            (pc_q),
    .ir            (ir_q),
    .rs_data       (rs_data),
    .pc_sel        (pc_sel),
    .pc_plus4      (pc_plus4),
    .next_pc       (next_pc),
    .misalign_cond (misalign_cond)
  );

  always_comb begin
    running    = (state_q == S_RUN);
    halt_latch = running && ir_write && (instr_in[31:26] == OP_HALT);

    // Latching HALT blocks a coincident PC commit, so the PC stays at the
    // HALT address.
    pc_en = running && pc_write && !halt_latch;

    ir_d = ir_q;
    if (running && ir_write) begin
      ir_d = instr_in;
    end

    pc_d       = pc_en ? next_pc : pc_q;
    misalign_d = misalign_q | (pc_en & misalign_cond);
    state_d    = halt_latch ? S_HALT : state_q;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      state_q    <= S_RUN;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      state_q    <= state_d;
      misalign_q <= misalign_d;
    end
  end

  assign fields   = instr_fields_t'(ir_q);
  assign pc       = pc_q;
  assign op       = fields.op;
  assign rs       = fields.rs;
  assign rt       = fields.rt;
  assign rd       = fields.rd;
  assign sa       = fields.sa;
  assign func     = fields.func;
  assign immd16   = ir_q[15:0];
  assign halted   = (state_q == S_HALT);
  assign misalign = misalign_q;

endmodule
